// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: two writeback requesters share the single write port of the
// 16 x 16-bit register file. A is the ALU writeback and B is the memory-load
// writeback. A round-robin pointer chooses between them. The winning write is
// registered and drives the register file one cycle after it is accepted. A
// saturating counter records the cycles in which both requesters were valid.
//
// Handshake (valid/ready): a requester raises X_valid and holds X_reg and
// X_data stable until it sees X_ready high at a rising edge. That edge is the
// acceptance edge. X_ready is combinational and is never high unless X_valid
// is high. At most one ready is high in any cycle. Dropping valid before the
// write is accepted is not allowed.
module rf_write_arbiter #(
  parameter int DATA_W       = 16,
  parameter int REG_AW       = 4,
  parameter int ZERO_DISCARD = 1,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [REG_AW-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [REG_AW-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              rf_wen,
  output logic [REG_AW-1:0] rf_reg,
  output logic [DATA_W-1:0] rf_data,
  output logic [CNT_W-1:0]  conflict_cnt
);

  // The round-robin pointer names the requester that wins the next conflict.
  typedef enum logic {PRIO_A = 1'b0, PRIO_B = 1'b1} prio_t;

  prio_t             prio;
  logic              accept;
  logic              both_valid;
  logic [REG_AW-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;
  logic              sel_wen;

  // The grant and the write-port mux. A lone requester always wins.
  always_comb begin
    both_valid = a_valid & b_valid;
    a_ready    = a_valid & (~b_valid | (prio == PRIO_A));
    b_ready    = b_valid & (~a_valid | (prio == PRIO_B));
    accept     = a_ready | b_ready;
    sel_reg    = a_reg;
    sel_data   = a_data;
    if (b_ready) begin
      sel_reg  = b_reg;
      sel_data = b_data;
    end
    // A write to r0 is consumed but never reaches the register file.
    sel_wen = accept & ~((ZERO_DISCARD != 0) && (sel_reg == '0));
  end

  // Register the winning write. Update the pointer and the conflict counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio         <= PRIO_A;
      rf_wen       <= 1'b0;
      rf_reg       <= '0;
      rf_data      <= '0;
      conflict_cnt <= '0;
    end else begin
      rf_wen <= sel_wen;
      if (accept) begin
        rf_reg  <= sel_reg;
        rf_data <= sel_data;
      end
      // The pointer moves only on a real conflict, and it goes to the loser.
      // A lone requester never takes priority away from the other one.
      if (both_valid) begin
        prio <= a_ready ? PRIO_B : PRIO_A;
      end
      if (both_valid && (conflict_cnt != '1)) begin
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single write port of the 16 x 16-bit register file between two writeback requesters.
  - Port A: ALU writeback.
  - Port B: memory-load writeback.
- Arbitrates with round-robin priority and registers the winning write.
- Drives the register-file write enable, destination index and data one cycle after acceptance.
- Keeps a saturating count of conflict cycles for performance debug.

Parameters:
- DATA_W, 16, width of write data.
- REG_AW, 4, width of register index (16 registers).
- ZERO_DISCARD, 1, when 1 an accepted write to register 0 is consumed but never drives rf_wen.
- CNT_W, 8, width of the conflict counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- a_valid  in  1  requester A has a write pending.
- a_reg  in  REG_AW  requester A destination register.
- a_data  in  DATA_W  requester A write data.
- a_ready  out  1  A's write is accepted this cycle (combinational).
- b_valid  in  1  requester B has a write pending.
- b_reg  in  REG_AW  requester B destination register.
- b_data  in  DATA_W  requester B write data.
- b_ready  out  1  B's write is accepted this cycle (combinational).
- rf_wen  out  1  register-file write enable (registered).
- rf_reg  out  REG_AW  register-file destination index (registered).
- rf_data  out  DATA_W  register-file write data (registered).
- conflict_cnt  out  CNT_W  saturating count of cycles with a_valid and b_valid both high.

Behaviour:
- Reset: on rst=0, asynchronously and regardless of clk:
  - rf_wen=0, rf_reg=0, rf_data=0, conflict_cnt=0, prio=A.
  - a_ready/b_ready follow their combinational equations (prio=A).
- Reset mid-operation: any write registered but not yet clocked into the register file is dropped; an in-flight acceptance is lost. Requesters must re-present after reset.
- State:
  - prio: 1-bit round-robin pointer (A or B). It is the only arbitration state.
  - Output registers rf_wen, rf_reg, rf_data.
  - conflict_cnt.
- Grant (combinational):
  - a_ready = a_valid & (~b_valid | prio==A)
  - b_ready = b_valid & (~a_valid | prio==B)
  - At most one ready per cycle. Ready is never asserted without the matching valid.
- Handshake: a requester holds valid, reg and data stable until it sees ready high at a rising edge. Deasserting valid before acceptance is illegal; behaviour is undefined.
- Acceptance (rising edge with X_ready=1):
  - rf_reg <= X_reg, rf_data <= X_data.
  - rf_wen <= 1, except rf_wen <= 0 when ZERO_DISCARD=1 and X_reg==0.
  - Latency: exactly 1 cycle from acceptance edge to rf_wen/rf_reg/rf_data visible. The register file captures on the following edge.
- No acceptance: rf_wen <= 0; rf_reg and rf_data hold their previous values.
- prio update:
  - Only when both valid: prio <= the loser, i.e. the opposite of the requester granted that cycle.
  - When only one requester is valid, prio is unchanged, so a lone requester does not steal priority.
- Fairness bound: under continuous contention grants strictly alternate A,B,A,B. Neither requester waits more than 1 cycle while the other is valid.
- Same destination register from both in one cycle: no merging. Both writes occur in grant order on consecutive cycles; the later grant's data is what remains.
- Throughput: one write per cycle sustained; there are no bubbles between back-to-back grants.
- conflict_cnt: increments by 1 on every edge where a_valid & b_valid; saturates at 2^CNT_W-1 (255) and holds. Cleared only by reset.

Test Plan:
- Reset then idle: rst=0 mid-cycle → all outputs 0 immediately. Release rst, no valids for 5 cycles → rf_wen=0, conflict_cnt=0, ready lines low.
- Single requester: a_valid=1, a_reg=3, a_data=16'hBEEF for 1 cycle → a_ready=1 same cycle. Next cycle rf_wen=1, rf_reg=3, rf_data=16'hBEEF, then rf_wen=0. prio remains A.
- Contention alternation: both valid 4 cycles with A data 16'h0001..0004 held per grant, B data 16'h00A1..00A4 → grant order A,B,A,B. rf_data sequence 0001,00A1,0002,00A2 on consecutive cycles. conflict_cnt=4.
- Priority retention: after a contention cycle in which A wins (prio=B), B idle and A writes twice alone, then both valid → B is granted first.
- Zero-register discard: b_valid=1, b_reg=0, b_data=16'h1234 → b_ready=1. Next cycle rf_wen=0, rf_reg=0, rf_data=16'h1234.
- Saturation and reset mid-write: hold both valid 300 cycles → conflict_cnt stops at 255. Assert rst=0 in the cycle after an acceptance → rf_wen drops to 0 immediately, counter 0, prio=A.
